mem_bus_arbiter: RTL and testbench

//   Shares one single-ported, ack-handshaked memory between the CPU instruction-fetch port (I) and load/store port (D).

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one ack-handshaked memory between the CPU fetch (I) and load/store (D) ports.
// Optional BUSY watchdog is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int D_BURST_MAX    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iport_req_i,
    input  logic [31:0] iport_addr_i,
    output logic [31:0] iport_rdata_o,
    output logic        iport_ack_o,
    input  logic        dport_req_i,
    input  logic        dport_we_i,
    input  logic [3:0]  dport_sel_i,
    input  logic [31:0] dport_addr_i,
    input  logic [31:0] dport_wdata_i,
    output logic [31:0] dport_rdata_o,
    output logic        dport_ack_o,
    output logic        stallreq_o,
    output logic        err_o,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_owner_d;
    logic [2:0]  r_burst_cnt;
    logic        w_grant_d, w_grant_i, w_tmo;
    logic        w_burst_full;

    assign w_burst_full = (r_burst_cnt == 3'(D_BURST_MAX));

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_wait;
    assign w_tmo = (r_state == S_BUSY) && (r_wait == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || r_state != S_BUSY) r_wait <= 8'd0;
        else                          r_wait <= r_wait + 8'd1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // D normally wins, but a full burst counter hands the slot to a waiting I
                if (dport_req_i && !(iport_req_i && w_burst_full)) w_grant_d = 1'b1;
                else if (iport_req_i)                             w_grant_i = 1'b1;
                if (w_grant_d || w_grant_i) w_state_nxt = S_BUSY;
            end
            S_BUSY:  if (mem_ack_i || w_tmo) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_d     <= 1'b0;
            r_burst_cnt   <= 3'd0;
            mem_cyc_o     <= 1'b0;
            mem_stb_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_sel_o     <= 4'h0;
            mem_addr_o    <= 32'h0;
            mem_wdata_o   <= 32'h0;
            iport_ack_o   <= 1'b0;
            dport_ack_o   <= 1'b0;
            iport_rdata_o <= 32'h0;
            dport_rdata_o <= 32'h0;
            err_o         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_owner_d   <= 1'b1;
                        mem_cyc_o   <= 1'b1;
                        mem_stb_o   <= 1'b1;
                        mem_we_o    <= dport_we_i;
                        mem_sel_o   <= dport_sel_i;
                        mem_addr_o  <= dport_addr_i;
                        mem_wdata_o <= dport_wdata_i;
                    end else if (w_grant_i) begin
                        r_owner_d   <= 1'b0;
                        mem_cyc_o   <= 1'b1;
                        mem_stb_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_sel_o   <= 4'hF;
                        mem_addr_o  <= iport_addr_i;
                        mem_wdata_o <= 32'h0;
                    end
                    if (!iport_req_i || w_grant_i)
                        r_burst_cnt <= 3'd0;
                    else if (w_grant_d && r_burst_cnt != 3'd7)
                        r_burst_cnt <= r_burst_cnt + 3'd1;
                end
                S_BUSY: begin
                    if (mem_ack_i || w_tmo) begin
                        mem_cyc_o <= 1'b0;
                        mem_stb_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        mem_sel_o <= 4'h0;
                        err_o     <= !mem_ack_i;
                        if (r_owner_d) begin
                            dport_ack_o   <= 1'b1;
                            dport_rdata_o <= mem_ack_i ? mem_rdata_i : 32'h0;
                        end else begin
                            iport_ack_o   <= 1'b1;
                            iport_rdata_o <= mem_ack_i ? mem_rdata_i : 32'h0;
                        end
                    end
                end
                S_DONE: begin
                    iport_ack_o <= 1'b0;
                    dport_ack_o <= 1'b0;
                    err_o       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign stallreq_o = !rst && ((iport_req_i && !iport_ack_o) || (dport_req_i && !dport_ack_o));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed per-cycle vector table for mem_bus_arbiter, plus a hand-written reset-hold sequence.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, mack = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dwd = '0, mrd = '0;
    logic [3:0]  dsel = '0;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic        iack, dack, stall, err, mcyc, mstb, mwe;
    logic [3:0]  msel;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.D_BURST_MAX(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .iport_req_i(ireq), .iport_addr_i(iaddr), .iport_rdata_o(irdata), .iport_ack_o(iack),
        .dport_req_i(dreq), .dport_we_i(dwe), .dport_sel_i(dsel), .dport_addr_i(daddr),
        .dport_wdata_i(dwd), .dport_rdata_o(drdata), .dport_ack_o(dack),
        .stallreq_o(stall), .err_o(err),
        .mem_cyc_o(mcyc), .mem_stb_o(mstb), .mem_we_o(mwe), .mem_sel_o(msel),
        .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_rdata_i(mrd), .mem_ack_i(mack)
    );

    typedef struct {
        int          tc;
        logic        rst, ireq, dreq, dwe, mack;
        logic [31:0] iaddr, daddr, dwd, mrd;
        logic [3:0]  dsel;
        logic        cyc, we, iack, dack, stall, err;
        logic [3:0]  sel;
        logic [31:0] addr, wd, ird, drd;
    } vec_t;

    vec_t tbl[$];
    vec_t v;
    int   total = 0, bad = 0;

    task automatic add();
        tbl.push_back(v);
    endtask

    task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    initial begin
        v = '{default: 0};
        // 1: I-only, zero-wait slave, then an ignored stray mem ack in IDLE
        v.tc = 1; add();
        v.ireq = 1; v.iaddr = 32'h10; v.stall = 1; add();
        v.mack = 1; v.mrd = 32'h3401_1100; v.cyc = 1; v.sel = 4'hF; v.addr = 32'h10; add();
        v.mack = 0; v.mrd = 0; v.cyc = 0; v.sel = 0; v.iack = 1; v.ird = 32'h3401_1100; v.stall = 0; add();
        v.ireq = 0; v.iack = 0; add();
        v.mack = 1; v.mrd = 32'hFFFF_FFFF; add();
        v.mack = 0; add();
        // 2: collision, D store first then I
        v.tc = 2; v.ireq = 1; v.iaddr = 32'h20; v.dreq = 1; v.dwe = 1; v.dsel = 4'h3;
        v.daddr = 32'h80; v.dwd = 32'hAABB_CCDD; v.stall = 1; add();
        v.mack = 1; v.mrd = 32'h5555_AAAA; v.cyc = 1; v.we = 1; v.sel = 4'h3; v.addr = 32'h80;
        v.wd = 32'hAABB_CCDD; add();
        v.mack = 0; v.cyc = 0; v.we = 0; v.sel = 0; v.dack = 1; v.drd = 32'h5555_AAAA; add();
        v.dreq = 0; v.dwe = 0; v.dsel = 0; v.dack = 0; add();
        v.mack = 1; v.mrd = 32'h1234_5678; v.cyc = 1; v.sel = 4'hF; v.addr = 32'h20; add();
        v.mack = 0; v.cyc = 0; v.sel = 0; v.iack = 1; v.ird = 32'h1234_5678; v.stall = 0; add();
        v.ireq = 0; v.iack = 0; add();
        // 3: D held continuously with I pending -> 4 D grants then I
        v.tc = 3; v.ireq = 1; v.iaddr = 32'h40; v.dreq = 1; v.dsel = 4'hF; v.stall = 1;
        for (int k = 0; k < 4; k++) begin
            v.daddr = 32'h100 + 32'(4 * k); add();
            v.mack = 1; v.mrd = 32'hD000_0000 + 32'(k); v.cyc = 1; v.sel = 4'hF; v.addr = v.daddr; add();
            v.mack = 0; v.cyc = 0; v.sel = 0; v.dack = 1; v.drd = v.mrd; add();
            v.dack = 0;
        end
        v.daddr = 32'h200; add();
        v.mack = 1; v.mrd = 32'h1000_0040; v.cyc = 1; v.sel = 4'hF; v.addr = 32'h40; add();
        v.mack = 0; v.cyc = 0; v.sel = 0; v.iack = 1; v.ird = 32'h1000_0040; add();
        v.ireq = 0; v.dreq = 0; v.iack = 0; v.stall = 0; add();
        // 4: D load with three wait states
        v.tc = 4; v.dreq = 1; v.daddr = 32'h200; v.dsel = 4'hF; v.stall = 1; add();
        v.cyc = 1; v.sel = 4'hF; v.addr = 32'h200; add(); add(); add();
        v.mack = 1; v.mrd = 32'hCAFE_F00D; add();
        v.mack = 0; v.cyc = 0; v.sel = 0; v.dack = 1; v.drd = 32'hCAFE_F00D; v.stall = 0; add();
        v.dreq = 0; v.dack = 0; add(); add();
        // 5: reset mid-BUSY, late slave ack afterwards
        v.tc = 5; v.ireq = 1; v.iaddr = 32'h300; v.stall = 1; add();
        v.cyc = 1; v.sel = 4'hF; v.addr = 32'h300; add();
        v.rst = 1; v.stall = 0; add();
        v.rst = 0; v.ireq = 0; v.mack = 1; v.mrd = 32'hDEAD_BEEF; v.cyc = 0; v.sel = 0; v.addr = 0;
        v.ird = 0; v.drd = 0; v.wd = 0; add();
        v.mack = 0; add();
`ifdef ARB_TIMEOUT_EN
        // 6: slave never acks -> abort after 8 BUSY cycles
        v.tc = 6; v.ireq = 1; v.iaddr = 32'h400; v.stall = 1; add();
        v.cyc = 1; v.sel = 4'hF; v.addr = 32'h400;
        for (int k = 0; k < 8; k++) add();
        v.cyc = 0; v.sel = 0; v.iack = 1; v.err = 1; v.ird = 0; v.stall = 0; add();
        v.ireq = 0; v.iack = 0; v.err = 0; add();
`endif

        rst = 1'b1;
        repeat (2) @(posedge clk);
        foreach (tbl[r]) begin
            @(posedge clk); #1;
            rst = tbl[r].rst; ireq = tbl[r].ireq; iaddr = tbl[r].iaddr; dreq = tbl[r].dreq;
            dwe = tbl[r].dwe; dsel = tbl[r].dsel; daddr = tbl[r].daddr; dwd = tbl[r].dwd;
            mack = tbl[r].mack; mrd = tbl[r].mrd;
            #4;
            chk("cyc",    r, 32'(mcyc),  32'(tbl[r].cyc));
            chk("stb",    r, 32'(mstb),  32'(tbl[r].cyc));
            chk("we",     r, 32'(mwe),   32'(tbl[r].we));
            chk("sel",    r, 32'(msel),  32'(tbl[r].sel));
            chk("addr",   r, maddr,      tbl[r].addr);
            chk("iack",   r, 32'(iack),  32'(tbl[r].iack));
            chk("irdata", r, irdata,     tbl[r].ird);
            chk("dack",   r, 32'(dack),  32'(tbl[r].dack));
            chk("drdata", r, drdata,     tbl[r].drd);
            chk("stall",  r, 32'(stall), 32'(tbl[r].stall));
            chk("err",    r, 32'(err),   32'(tbl[r].err));
            if (tbl[r].we) chk("wdata", r, mwdata, tbl[r].wd);
        end

        // reset held with both requests up: nothing granted, stall forced low; D wins after release
        @(posedge clk); #1;
        rst = 1; ireq = 1; iaddr = 32'h500; dreq = 1; dwe = 0; dsel = 4'hF; daddr = 32'h600; mack = 0;
        repeat (2) begin
            @(posedge clk); #4;
            chk("rst_cyc",   -1, 32'(mcyc),  32'd0);
            chk("rst_stall", -1, 32'(stall), 32'd0);
        end
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #4;
        chk("post_rst_cyc",  -1, 32'(mcyc), 32'd1);
        chk("post_rst_addr", -1, maddr,     32'h600);
        @(posedge clk); #1; rst = 1; ireq = 0; dreq = 0;
        @(posedge clk); #1; rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
